mem_pattern_filler: RTL and testbench

- Parametrised successor to the team's memory filler: writes arr_size words starting at a programmable base address over the AW/W/B write-channel interface.
- Adds a start pulse, four data-pattern modes (constant, incrementing, address, LFSR) and a bounded number of outstanding writes.
- Counts and flags error write responses.
- Sits between the sort-circuit control logic and the array memory; it pre-loads test and working arrays before sorting.

---
 rtl/mem_filler_pkg.sv | 25 ++
 rtl/mem_pattern_filler_if.sv | 28 ++
 rtl/fill_pattern_gen.sv | 66 ++++++
 rtl/mem_pattern_filler.sv | 154 +++++++++++++++
 tb/tb_mem_pattern_filler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_filler_pkg.sv
// Shared encodings for the memory pattern filler: data modes, FSM states,
// LFSR constants and the OKAY response code.
package mem_filler_pkg;

  // Data pattern modes, as presented on the mode input.
  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INCR  = 2'd1;
  localparam logic [1:0] MODE_ADDR  = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Galois feedback taps and the seed used when the caller supplies zero
  // (an all-zero state would lock the LFSR).
  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

  localparam int unsigned RESP_OKAY = 0;

endpackage

// File: rtl/mem_pattern_filler_if.sv
// AW/W/B write-channel bundle between the filler (master) and the memory (slave).
interface mem_pattern_filler_if #(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned RESP_WDTH = 2
);

  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_WDTH-1:0] aw_address;
  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_WDTH-1:0] w_data;
  logic                 b_valid;
  logic [RESP_WDTH-1:0] b_resp;
  logic                 b_ready;

  modport master (
    output aw_valid, aw_address, w_valid, w_data, b_ready,
    input  aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  aw_valid, aw_address, w_valid, w_data, b_ready,
    output aw_ready, w_ready, b_valid, b_resp
  );

endinterface

// File: rtl/fill_pattern_gen.sv
// Write-data pattern generator: captures mode and seed on load, keeps the
// LFSR state, and produces the data word for beat k.
module fill_pattern_gen
  import mem_filler_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [1:0]           mode,
  input  logic [DATA_WDTH-1:0] seed,
  input  logic [ADDR_WDTH-1:0] base,
  input  logic [ADDR_WDTH:0]   k,
  output logic [DATA_WDTH-1:0] data
);

  localparam logic [DATA_WDTH-1:0] Poly     = DATA_WDTH'(LFSR_POLY);
  localparam logic [DATA_WDTH-1:0] DefSeed  = DATA_WDTH'(LFSR_DEFAULT_SEED);

  logic [1:0]           mode_q;
  logic [DATA_WDTH-1:0] seed_q;
  logic [DATA_WDTH-1:0] lfsr_q;
  logic [DATA_WDTH-1:0] lfsr_d;
  logic [ADDR_WDTH-1:0] addr_k;

  // Next LFSR value: shift right, fold in the taps when a one drops out.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ Poly;
    end
  end

  // Capture mode/seed on load; advance the LFSR once per accepted W beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_CONST;
      seed_q <= '0;
      lfsr_q <= '0;
    end else if (load) begin
      mode_q <= mode;
      seed_q <= seed;
      lfsr_q <= (seed == '0) ? DefSeed : seed;
    end else if (step) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign addr_k = base + k[ADDR_WDTH-1:0];

  // Mode mux for the data of beat k.
  always_comb begin
    data = seed_q;
    unique case (mode_q)
      MODE_CONST: data = seed_q;
      MODE_INCR:  data = seed_q + DATA_WDTH'(k);
      MODE_ADDR:  data = DATA_WDTH'(addr_k);
      MODE_LFSR:  data = lfsr_q;
      default:    data = seed_q;
    endcase
  end

endmodule

// File: rtl/mem_pattern_filler.sv
// Memory pattern filler: on start, writes arr_size words from base_addr over
// the AW/W/B channels with a bounded number of outstanding writes, and
// counts error responses.
module mem_pattern_filler
  import mem_filler_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned RESP_WDTH = 2,
  parameter int unsigned MAX_OUTST = 4,   // 1..15
  parameter int unsigned CNT_WDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [ADDR_WDTH-1:0] base_addr,
  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic [DATA_WDTH-1:0] seed,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WDTH-1:0]  err_count,
  mem_pattern_filler_if.master bus
);

  typedef logic [ADDR_WDTH:0] cnt_t;

  state_e               state_q, state_d;
  logic [ADDR_WDTH-1:0] base_q;
  cnt_t                 size_q;
  cnt_t                 aw_cnt_q, w_cnt_q, b_cnt_q;
  cnt_t                 aw_cnt_nxt, w_cnt_nxt;
  cnt_t                 issued_min;
  logic                 error_q;
  logic [CNT_WDTH-1:0]  err_cnt_q;
  logic                 start_ok;
  logic                 aw_hs, w_hs, b_hs;
  logic                 b_bad;

  assign start_ok   = start && ((state_q == StIdle) || (state_q == StDone));
  assign aw_hs      = bus.aw_valid && bus.aw_ready;
  assign w_hs       = bus.w_valid && bus.w_ready;
  assign b_hs       = bus.b_valid && bus.b_ready;
  assign b_bad      = bus.b_resp != RESP_WDTH'(RESP_OKAY);
  assign aw_cnt_nxt = aw_cnt_q + cnt_t'(aw_hs);
  assign w_cnt_nxt  = w_cnt_q + cnt_t'(w_hs);
  // Only beats whose address and data are both out can be answered.
  assign issued_min = (aw_cnt_q < w_cnt_q) ? aw_cnt_q : w_cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = (arr_size == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // Use post-handshake counts so the final beat moves us on directly.
        if ((aw_cnt_nxt == size_q) && (w_cnt_nxt == size_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (b_cnt_q == size_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and counters; valids depend only on
  // registered values so they cannot drop mid-beat.
  always_comb begin
    busy         = (state_q == StRun) || (state_q == StDrain);
    done         = (state_q == StDone);
    bus.aw_valid = (state_q == StRun) && (aw_cnt_q < size_q) &&
                   (32'(cnt_t'(aw_cnt_q - b_cnt_q)) < MAX_OUTST);
    bus.w_valid  = (state_q == StRun) && (w_cnt_q < size_q) &&
                   (32'(cnt_t'(w_cnt_q - b_cnt_q)) < MAX_OUTST);
    bus.b_ready  = busy && (b_cnt_q < issued_min);
  end

  assign bus.aw_address = base_q + aw_cnt_q[ADDR_WDTH-1:0];
  assign error          = error_q;
  assign err_count      = err_cnt_q;

  // Fill parameters and beat counters; start clears and re-arms them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      size_q   <= '0;
      aw_cnt_q <= '0;
      w_cnt_q  <= '0;
      b_cnt_q  <= '0;
    end else if (start_ok) begin
      base_q   <= base_addr;
      size_q   <= arr_size;
      aw_cnt_q <= '0;
      w_cnt_q  <= '0;
      b_cnt_q  <= '0;
    end else begin
      aw_cnt_q <= aw_cnt_nxt;
      w_cnt_q  <= w_cnt_nxt;
      if (b_hs) begin
        b_cnt_q <= b_cnt_q + cnt_t'(1);
      end
    end
  end

  // Sticky error flag and saturating error-response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (start_ok) begin
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (b_hs && b_bad) begin
      error_q <= 1'b1;
      if (err_cnt_q != {CNT_WDTH{1'b1}}) begin
        err_cnt_q <= err_cnt_q + CNT_WDTH'(1);
      end
    end
  end

  fill_pattern_gen #(
    .ADDR_WDTH (ADDR_WDTH),
    .DATA_WDTH (DATA_WDTH)
  ) u_pattern (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .step  (w_hs),
    .mode  (mode),
    .seed  (seed),
    .base  (base_q),
    .k     (w_cnt_q),
    .data  (bus.w_data)
  );

endmodule

// File: tb/tb_mem_pattern_filler.sv
// Randomised bench for mem_pattern_filler with an in-bench write-slave and
// a reference model of the expected address/data/response sequence.
module tb_mem_pattern_filler;
  import mem_filler_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 2;
  localparam int unsigned MO = 2;
  localparam int unsigned CW = 8;
  localparam int          Budget = 400;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      mode;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     arr_size;
  logic [DW-1:0]   seed;
  logic            busy, done, error;
  logic [CW-1:0]   err_count;

  always #5 clk = ~clk;

  mem_pattern_filler_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) bus ();

  mem_pattern_filler #(
    .ADDR_WDTH (AW),
    .DATA_WDTH (DW),
    .RESP_WDTH (RW),
    .MAX_OUTST (MO),
    .CNT_WDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .arr_size  (arr_size),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_count (err_count),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model configuration for the current fill.
  int          c_base, c_size;
  logic [1:0]  c_mode;
  logic [31:0] c_seed;
  logic [1:0]  resp_tab[$];
  int          first_aw, last_aw, first_w, last_w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic rand_pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [31:0] ref_addr(input int k);
    return 32'((c_base + k) % (1 << AW));
  endfunction

  function automatic logic [31:0] ref_data(input int k);
    logic [31:0] s;
    case (c_mode)
      MODE_CONST: return c_seed;
      MODE_INCR:  return c_seed + 32'(k);
      MODE_ADDR:  return ref_addr(k);
      default: begin
        s = (c_seed == 32'd0) ? 32'd1 : c_seed;
        for (int i = 0; i < k; i++) s = lfsr_step(s);
        return s;
      end
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_error"}, 64'(error), 64'(0));
    check({tag, "_errcnt"}, 64'(err_count), 64'(0));
    check({tag, "_awvalid"}, 64'(bus.aw_valid), 64'(0));
    check({tag, "_awaddr"}, 64'(bus.aw_address), 64'(0));
    check({tag, "_wvalid"}, 64'(bus.w_valid), 64'(0));
    check({tag, "_wdata"}, 64'(bus.w_data), 64'(0));
    check({tag, "_bready"}, 64'(bus.b_ready), 64'(0));
  endtask

  task automatic slave_idle();
    bus.aw_ready = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b0;
    bus.b_resp   = '0;
  endtask

  // One complete fill. rmode: 0 all OKAY, 1 random, 2 the list 0,2,0,3.
  // b_hold/aw_hold stall B/AW for the first cycles; spur_at pulses start
  // mid-fill; rst_at resets mid-fill and ends the task.
  task automatic run_fill(input int b, input int sz, input logic [1:0] m, input logic [31:0] sd,
                          input int aw_p, input int w_p, input int b_p, input int rmode,
                          input int b_hold, input int aw_hold, input int spur_at,
                          input int rst_at);
    int          aw_n = 0, w_n = 0, b_n = 0, exp_err = 0, done_cyc = -1, last_b = -1;
    logic        aw_wait = 1'b0, w_wait = 1'b0;
    logic [31:0] aw_prev = '0, w_prev = '0;
    logic [1:0]  fixed[4] = '{2'd0, 2'd2, 2'd0, 2'd3};
    c_base = b; c_size = sz; c_mode = m; c_seed = sd;
    first_aw = -1; last_aw = -1; first_w = -1; last_w = -1;
    resp_tab.delete();
    for (int i = 0; i < sz; i++) begin
      case (rmode)
        1:       resp_tab.push_back(($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0);
        2:       resp_tab.push_back(fixed[i % 4]);
        default: resp_tab.push_back(2'd0);
      endcase
    end
    @(negedge clk);
    start = 1'b1; mode = m; base_addr = AW'(b); arr_size = (AW + 1)'(sz); seed = sd;
    slave_idle();
    for (int cyc = 0; cyc < Budget; cyc++) begin
      @(negedge clk);
      // Scramble the start-side inputs: the fill must use the latched copies.
      start = (cyc == spur_at);
      mode = 2'($urandom); base_addr = AW'($urandom); arr_size = (AW + 1)'($urandom);
      seed = $urandom;
      if (cyc == rst_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        slave_idle();
        return;
      end
      bus.aw_ready = (cyc >= aw_hold) && rand_pct(aw_p);
      bus.w_ready  = rand_pct(w_p);
      bus.b_valid  = (b_n < imin(aw_n, w_n)) && (cyc >= b_hold) && rand_pct(b_p);
      bus.b_resp   = bus.b_valid ? resp_tab[b_n] : 2'd0;
      #1;
      if (sz == 0) begin
        check("zero_awvalid", 64'(bus.aw_valid), 64'(0));
        check("zero_wvalid", 64'(bus.w_valid), 64'(0));
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (aw_wait) begin
        check("aw_hold_valid", 64'(bus.aw_valid), 64'(1));
        check("aw_hold_addr", 64'(bus.aw_address), 64'(aw_prev));
      end
      if (w_wait) begin
        check("w_hold_valid", 64'(bus.w_valid), 64'(1));
        check("w_hold_data", 64'(bus.w_data), 64'(w_prev));
      end
      if (cyc < aw_hold && sz > 0) begin
        check("aw_stall_valid", 64'(bus.aw_valid), 64'(1));
        check("aw_stall_addr", 64'(bus.aw_address), 64'(ref_addr(0)));
      end
      if (b_hold > 0 && cyc == b_hold - 1) begin
        check("bhold_aw_n", 64'(aw_n), 64'(imin(MO, sz)));
        check("bhold_w_n", 64'(w_n), 64'(imin(MO, sz)));
        if (sz > int'(MO)) begin
          check("bhold_awvalid", 64'(bus.aw_valid), 64'(0));
          check("bhold_wvalid", 64'(bus.w_valid), 64'(0));
        end
      end
      if (bus.b_ready) check("b_ready_due", 64'(b_n < imin(aw_n, w_n)), 64'(1));
      if (bus.aw_valid && bus.aw_ready) begin
        check("aw_addr", 64'(bus.aw_address), 64'(ref_addr(aw_n)));
        aw_n++;
        check("aw_outst", 64'((aw_n - b_n) <= int'(MO)), 64'(1));
        if (first_aw < 0) first_aw = cyc;
        last_aw = cyc;
      end
      if (bus.w_valid && bus.w_ready) begin
        check("w_data", 64'(bus.w_data), 64'(ref_data(w_n)));
        w_n++;
        check("w_outst", 64'((w_n - b_n) <= int'(MO)), 64'(1));
        if (first_w < 0) first_w = cyc;
        last_w = cyc;
      end
      if (bus.b_valid && bus.b_ready) begin
        if (resp_tab[b_n] != 2'd0) exp_err++;
        b_n++;
        last_b = cyc;
      end
      aw_wait = bus.aw_valid && !bus.aw_ready;
      aw_prev = 32'(bus.aw_address);
      w_wait  = bus.w_valid && !bus.w_ready;
      w_prev  = bus.w_data;
    end
    check("done_seen", 64'(done_cyc >= 0), 64'(1));
    check("aw_count", 64'(aw_n), 64'(sz));
    check("w_count", 64'(w_n), 64'(sz));
    check("b_count", 64'(b_n), 64'(sz));
    check("end_busy", 64'(busy), 64'(0));
    check("end_error", 64'(error), 64'(exp_err > 0));
    check("end_errcnt", 64'(err_count), 64'(exp_err));
    if (sz > 0) check("done_latency", 64'(done_cyc - last_b), 64'(2));
    else        check("done_zero", 64'(done_cyc), 64'(0));
    @(negedge clk);
    start = 1'b0;
    slave_idle();
    #1;
    check("done_level", 64'(done), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode = '0; base_addr = '0; arr_size = '0; seed = '0;
    slave_idle();
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming INCR fill, one beat per cycle.
    run_fill(0, 16, MODE_INCR, 32'h100, 100, 100, 100, 0, 0, 0, -1, -1);
    check("aw_back2back", 64'(last_aw - first_aw), 64'(15));
    check("w_back2back", 64'(last_w - first_w), 64'(15));

    // Address wrap with ADDR data.
    run_fill(14, 4, MODE_ADDR, $urandom, 100, 100, 100, 0, 0, 0, -1, -1);

    // Outstanding limit while B is held off, then release.
    run_fill(3, 5, MODE_CONST, $urandom, 100, 100, 100, 0, 10, 0, -1, -1);

    // Zero-length fill.
    run_fill(5, 0, MODE_INCR, $urandom, 100, 100, 100, 0, 0, 0, -1, -1);

    // LFSR with zero seed, random W stalls, AW held off for 3 cycles.
    run_fill(int'($urandom_range(15, 0)), 12, MODE_LFSR, 32'd0, 100, 50, 70, 0, 0, 3, -1, -1);

    // Error responses 0,2,0,3.
    run_fill(7, 4, MODE_INCR, $urandom, 100, 100, 100, 2, 0, 0, -1, -1);

    // A start pulse during RUN is ignored.
    run_fill(2, 8, MODE_INCR, $urandom, 100, 100, 100, 0, 0, 0, 3, -1);

    // Reset mid-fill, then a fresh fill afterwards.
    run_fill(0, 10, MODE_INCR, $urandom, 100, 100, 100, 0, 0, 0, -1, 4);
    run_fill(9, 6, MODE_LFSR, $urandom, 80, 80, 80, 1, 0, 0, -1, -1);

    // Random fills across all modes and stall mixes.
    for (int t = 0; t < 10; t++) begin
      run_fill(int'($urandom_range(15, 0)), int'($urandom_range(16, 0)), 2'($urandom), $urandom,
               int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
               int'($urandom_range(100, 30)), 1, 0, 0, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
